// File: rtl/i_alu_branch_jump.sv
// I-type ALU, branch-compare and jump-target unit for a word-addressed single-cycle core.
// All results are combinational except the jal link value and the addi overflow flag.
module i_alu_branch_jump #(
   parameter int PC_W = 9
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     inst,
   input  logic [PC_W-1:0] pc,
   input  logic [31:0]     alu_i1,
   input  logic [15:0]     alu_i2,
   output logic [31:0]     alu_out,
   input  logic [31:0]     br_reg1,
   input  logic [31:0]     br_reg2,
   output logic [PC_W-1:0] br_new_pc,
   output logic            br_taken,
   input  logic [31:0]     jj_reg1,
   output logic [PC_W-1:0] jj_new_pc,
   output logic [PC_W-1:0] j_out,
   output logic            ovf
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] FUNCT_JR   = 6'h08;

   logic [5:0]      opcode;
   logic [5:0]      funct;
   logic [15:0]     imm;
   logic [25:0]     target;
   logic [31:0]     alu_sext;
   logic [31:0]     alu_zext;
   logic [31:0]     alu_sum;
   logic [PC_W-1:0] br_offset;
   logic [PC_W-1:0] pc_plus1;
   logic [PC_W-1:0] j_out_reg;
   logic            ovf_reg;
   logic            ovf_next;

   assign opcode   = inst[31:26];
   assign funct    = inst[5:0];
   assign imm      = inst[15:0];
   assign target   = inst[25:0];
   assign alu_sext = {{16{alu_i2[15]}}, alu_i2};
   assign alu_zext = {16'h0000, alu_i2};
   assign alu_sum  = alu_i1 + alu_sext;
   assign pc_plus1 = pc + PC_W'(1);

   // Only the low PC_W bits of the offset matter: the branch target wraps modulo 2^PC_W.
   assign br_offset = PC_W'({{16{imm[15]}}, imm});

   // Signed overflow: operands share a sign and the sum's sign differs from it.
   assign ovf_next = (alu_i1[31] == alu_sext[31]) && (alu_sum[31] != alu_i1[31]);

   always_comb begin
      alu_out = '0;
      case (opcode)
         OP_ADDI, OP_ADDIU: alu_out = alu_sum;
         OP_SLTI:           alu_out = {31'h0, $signed(alu_i1) < $signed(alu_sext)};
         OP_SLTIU:          alu_out = {31'h0, alu_i1 < alu_sext};
         OP_ANDI:           alu_out = alu_i1 & alu_zext;
         OP_ORI:            alu_out = alu_i1 | alu_zext;
         OP_XORI:           alu_out = alu_i1 ^ alu_zext;
         OP_LUI:            alu_out = {alu_i2, 16'h0000};
         default:           alu_out = '0;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (opcode)
         OP_BEQ:  br_taken = (br_reg1 == br_reg2);
         OP_BNE:  br_taken = (br_reg1 != br_reg2);
         OP_BLEZ: br_taken = br_reg1[31] || (br_reg1 == 32'h0);
         OP_BGTZ: br_taken = !br_reg1[31] && (br_reg1 != 32'h0);
         default: br_taken = 1'b0;
      endcase
   end

   assign br_new_pc = br_taken ? (pc + br_offset) : pc;

   always_comb begin
      jj_new_pc = pc_plus1;
      if (opcode == OP_J || opcode == OP_JAL) begin
         jj_new_pc = target[PC_W-1:0];
      end else if (opcode == OP_SPECIAL && funct == FUNCT_JR) begin
         jj_new_pc = jj_reg1[PC_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_out_reg <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         if (opcode == OP_JAL) begin
            j_out_reg <= pc_plus1;
         end
         if (opcode == OP_ADDI) begin
            ovf_reg <= ovf_next;
         end
      end
   end

   assign j_out = j_out_reg;
   assign ovf   = ovf_reg;

endmodule

// File: tb/tb_i_alu_branch_jump.sv
// Bench for i_alu_branch_jump: directed cases, a mid-cycle reset pulse, then random
// transactions compared against an integer-arithmetic reference model.
module tb_i_alu_branch_jump;

   localparam int PC_W = 9;
   localparam int PC_M = 1 << PC_W;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [31:0]     inst = '0;
   logic [PC_W-1:0] pc = '0;
   logic [31:0]     alu_i1 = '0;
   logic [15:0]     alu_i2 = '0;
   logic [31:0]     alu_out;
   logic [31:0]     br_reg1 = '0;
   logic [31:0]     br_reg2 = '0;
   logic [PC_W-1:0] br_new_pc;
   logic            br_taken;
   logic [31:0]     jj_reg1 = '0;
   logic [PC_W-1:0] jj_new_pc;
   logic [PC_W-1:0] j_out;
   logic            ovf;

   int n_checks = 0;
   int n_errors = 0;
   int exp_j    = 0;
   int exp_ovf  = 0;
   int txn_id   = 0;

   i_alu_branch_jump #(.PC_W(PC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inst      (inst),
      .pc        (pc),
      .alu_i1    (alu_i1),
      .alu_i2    (alu_i2),
      .alu_out   (alu_out),
      .br_reg1   (br_reg1),
      .br_reg2   (br_reg2),
      .br_new_pc (br_new_pc),
      .br_taken  (br_taken),
      .jj_reg1   (jj_reg1),
      .jj_new_pc (jj_new_pc),
      .j_out     (j_out),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (plain integer arithmetic) ----------------
   function automatic longint s32(input logic [31:0] v);
      longint r;
      r = v;
      if (r >= 64'sd2147483648) r = r - 64'sd4294967296;
      return r;
   endfunction

   function automatic longint s16(input logic [15:0] v);
      longint r;
      r = v;
      if (r >= 32768) r = r - 65536;
      return r;
   endfunction

   function automatic longint wrap32(input longint v);
      longint r;
      r = v % 64'sd4294967296;
      if (r < 0) r = r + 64'sd4294967296;
      return r;
   endfunction

   function automatic logic [31:0] m_alu(input int op, input logic [31:0] a, input logic [15:0] b);
      longint sa, sb, ua, ub, ubz;
      sa  = s32(a);
      sb  = s16(b);
      ua  = a;
      ub  = wrap32(sb);
      ubz = b;
      case (op)
         8, 9:    return 32'(wrap32(sa + sb));
         10:      return (sa < sb) ? 32'd1 : 32'd0;
         11:      return (ua < ub) ? 32'd1 : 32'd0;
         12:      return a & 32'(ubz);
         13:      return a | 32'(ubz);
         14:      return a ^ 32'(ubz);
         15:      return 32'(ubz * 65536);
         default: return 32'd0;
      endcase
   endfunction

   function automatic int m_ovf(input logic [31:0] a, input logic [15:0] b);
      longint s;
      s = s32(a) + s16(b);
      return (s > 64'sd2147483647 || s < -64'sd2147483648) ? 1 : 0;
   endfunction

   function automatic int m_taken(input int op, input logic [31:0] r1, input logic [31:0] r2);
      case (op)
         4:       return (r1 == r2) ? 1 : 0;
         5:       return (r1 != r2) ? 1 : 0;
         6:       return (s32(r1) <= 0) ? 1 : 0;
         7:       return (s32(r1) > 0) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int m_mod_pc(input longint v);
      longint r;
      r = v % PC_M;
      if (r < 0) r = r + PC_M;
      return int'(r);
   endfunction

   function automatic int m_jj(input logic [31:0] ins, input int p, input logic [31:0] r);
      int op, fn;
      op = int'(ins >> 26);
      fn = int'(ins % 64);
      if (op == 2 || op == 3) return int'((ins % 67108864) % PC_M);
      if (op == 0 && fn == 8) return int'(r % PC_M);
      return m_mod_pc(p + 1);
   endfunction

   // Check combinational outputs, clock once, update model, check registered outputs.
   task automatic do_txn(input string tag);
      int op, tk, bpc;
      op  = int'(inst >> 26);
      tk  = m_taken(op, br_reg1, br_reg2);
      bpc = (tk != 0) ? m_mod_pc(longint'(pc) + s16(inst[15:0])) : int'(pc);
      #1;
      check_eq({tag, ":alu_out"},   alu_out,         m_alu(op, alu_i1, alu_i2));
      check_eq({tag, ":br_taken"},  32'(br_taken),   32'(tk));
      check_eq({tag, ":br_new_pc"}, 32'(br_new_pc),  32'(bpc));
      check_eq({tag, ":jj_new_pc"}, 32'(jj_new_pc),  32'(m_jj(inst, int'(pc), jj_reg1)));
      @(posedge clk);
      if (rst_n) begin
         if (op == 3) exp_j = m_mod_pc(longint'(pc) + 1);
         if (op == 8) exp_ovf = m_ovf(alu_i1, alu_i2);
      end
      #1;
      check_eq({tag, ":j_out"}, 32'(j_out), 32'(exp_j));
      check_eq({tag, ":ovf"},   32'(ovf),   32'(exp_ovf));
      $display("txn %0d %s op=%02h pc=%03h alu_out=%08h br_taken=%0b br_new_pc=%03h jj_new_pc=%03h j_out=%03h ovf=%0b",
               txn_id, tag, op, pc, alu_out, br_taken, br_new_pc, jj_new_pc, j_out, ovf);
      txn_id++;
   endtask

   function automatic logic [31:0] pick_word(input int sel);
      case (sel)
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'h0000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int opsel;
      logic [31:0] rnd;
      logic [5:0] op;

      #2;
      check_eq("reset:j_out", 32'(j_out), 32'd0);
      check_eq("reset:ovf",   32'(ovf),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // addi 4 + (-1)
      inst = {6'h08, 26'h0}; alu_i1 = 32'd4; alu_i2 = 16'hFFFF;
      do_txn("addi_neg");
      // addi overflow
      inst = {6'h08, 26'h0}; alu_i1 = 32'h7FFF_FFFF; alu_i2 = 16'h0001;
      do_txn("addi_ovf");
      // beq taken backwards, then not taken
      inst = {6'h04, 5'd1, 5'd2, 16'hFFFD}; pc = 9'd10; br_reg1 = 32'd5; br_reg2 = 32'd5;
      do_txn("beq_taken");
      br_reg2 = 32'd6;
      do_txn("beq_not");
      // bne wraps past the top of instruction memory
      inst = {6'h05, 5'd1, 5'd2, 16'h0002}; pc = 9'd511;
      do_txn("bne_wrap");
      // jal
      inst = {6'h03, 26'h3FF_FFE5}; pc = 9'd20;
      do_txn("jal");
      // jr, link value must hold
      inst = {6'h00, 5'd3, 15'h0, 6'h08}; jj_reg1 = 32'h0000_0123;
      do_txn("jr");

      // asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      exp_j = 0;
      exp_ovf = 0;
      check_eq("async_rst:j_out", 32'(j_out), 32'd0);
      check_eq("async_rst:ovf",   32'(ovf),   32'd0);
      inst = {6'h03, 26'h000_0055}; pc = 9'd100;
      do_txn("rst_hold_jal");
      inst = {6'h08, 26'h0}; alu_i1 = 32'h7FFF_FFFF; alu_i2 = 16'h0001;
      do_txn("rst_hold_addi");
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         opsel = int'($urandom_range(0, 19));
         if (opsel < 16) op = 6'(opsel);
         else begin
            rnd = $urandom();
            op = rnd[31:26];
         end
         rnd = $urandom();
         inst = {op, rnd[25:0]};
         if ($urandom_range(0, 3) == 0) inst[31:26] = 6'h00;
         if (inst[31:26] == 6'h00 && $urandom_range(0, 1) == 1) inst[5:0] = 6'h08;
         rnd = $urandom();
         pc = ($urandom_range(0, 7) == 0) ? 9'h1FF : rnd[8:0];
         alu_i1 = pick_word(int'($urandom_range(0, 9)));
         rnd = $urandom();
         case ($urandom_range(0, 5))
            0:       alu_i2 = 16'hFFFF;
            1:       alu_i2 = 16'h8000;
            2:       alu_i2 = 16'h0001;
            default: alu_i2 = rnd[15:0];
         endcase
         br_reg1 = pick_word(int'($urandom_range(0, 9)));
         br_reg2 = ($urandom_range(0, 2) == 0) ? br_reg1 : pick_word(int'($urandom_range(0, 9)));
         jj_reg1 = $urandom();
         do_txn("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/i_alu_branch_jump.md
I_ALU_BRANCH_JUMP -- requirements
Module: i_alu_branch_jump

Interface
REQ-001 SHALL have parameter: PC_W, default 9, program-counter width in instruction-memory words.
REQ-002 SHALL have port: clk  input  1  single clock; state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: inst  input  32  instruction; opcode [31:26], rs [25:21], rt [20:16], imm [15:0], target [25:0], funct [5:0].
REQ-005 SHALL have port: pc  input  PC_W  address of the current instruction.
REQ-006 SHALL have port: alu_i1  input  32  rs register value for I-type ALU operations.
REQ-007 SHALL have port: alu_i2  input  16  immediate for I-type ALU operations.
REQ-008 SHALL have port: alu_out  output  32  I-type ALU result; combinational.
REQ-009 SHALL have port: br_reg1 / br_reg2  input  32 each  rs / rt values for branch compares.
REQ-010 SHALL have port: br_new_pc  output  PC_W  branch PC, before the caller's +1; combinational.
REQ-011 SHALL have port: br_taken  output  1  branch condition true; combinational.
REQ-012 SHALL have port: jj_reg1  input  32  register value for jr.
REQ-013 SHALL have port: jj_new_pc  output  PC_W  jump target; combinational.
REQ-014 SHALL have port: j_out  output  PC_W  registered link value, PC+1 of the last jal.
REQ-015 SHALL have port: ovf  output  1  registered flag, set by the last addi signed overflow.

Function
REQ-016 SHALL decode the I-type ALU opcodes in alu_out as follows (sext/zext = sign-/zero-extend to 32 bits):
- 0x08 addi: alu_i1 + sext(alu_i2), modulo 2^32.
- 0x09 addiu: same sum, never flags overflow.
- 0x0A slti: signed compare, result 1 or 0.
- 0x0B sltiu: unsigned compare against sext(alu_i2), result 1 or 0.
- 0x0C andi, 0x0D ori, 0x0E xori: operate with zext(alu_i2).
- 0x0F lui: {alu_i2, 16'h0}.
REQ-017 SHALL drive alu_out = 0 for any other opcode.
REQ-018 SHALL compute branch conditions: 0x04 beq br_reg1==br_reg2; 0x05 bne !=; 0x06 blez signed br_reg1<=0; 0x07 bgtz signed br_reg1>0; any other opcode br_taken=0.
REQ-019 SHALL drive br_new_pc = pc + sext(imm) truncated to PC_W when br_taken=1, else pc; wrap-around modulo 2^PC_W.
REQ-020 SHALL drive jj_new_pc as follows:
- 0x02 j and 0x03 jal: target[PC_W-1:0].
- opcode 0x00 with funct 0x08 (jr): jj_reg1[PC_W-1:0].
- otherwise: pc+1, modulo 2^PC_W.
REQ-021 SHALL load j_out <= pc+1 (mod 2^PC_W) on each rising clk edge where opcode is 0x03; otherwise j_out holds.
REQ-022 SHALL update ovf only on rising edges where opcode is 0x08: ovf <= 1 if the operands have equal signs and the sum sign differs, else 0; otherwise ovf holds.
REQ-023 SHALL let combinational outputs follow inputs within the same cycle, with no clock dependency and no latches.

Reset
REQ-024 SHALL clear j_out and ovf to 0 immediately when rst_n goes low, independent of clk.
REQ-025 SHALL hold j_out and ovf at 0 while rst_n is low, including on clock edges with jal or addi present.
REQ-026 SHALL leave combinational outputs unaffected by rst_n.

Verification
REQ-027 SHALL pass: addi, alu_i1=4, alu_i2=0xFFFF -> alu_out=3; after the edge, ovf=0.
REQ-028 SHALL pass: addi, alu_i1=0x7FFFFFFF, alu_i2=1 -> alu_out=0x80000000; after the edge, ovf=1.
REQ-029 SHALL pass: beq, regs 5/5, pc=10, imm=0xFFFD -> br_taken=1, br_new_pc=7; with regs 5/6 -> br_taken=0, br_new_pc=10.
REQ-030 SHALL pass: bne, pc=511, imm=2, regs unequal -> br_new_pc=1 (wrap).
REQ-031 SHALL pass: jal, target=0x3FF_FFE5, pc=20 -> jj_new_pc=0x1E5; after the edge, j_out=21.
REQ-032 SHALL pass: jr, jj_reg1=0x123 -> jj_new_pc=0x123, j_out unchanged; rst_n pulsed low mid-cycle -> j_out=0, ovf=0 with no clk edge needed.
